riscv_mem_responder: RTL
========================

Name: riscv_mem_responder

Overview:
- Memory-side responder for the riscv_core instruction-fetch and data buses.
- Serves instruction words combinationally on the fetch port and services core load/store requests on the data port with one-cycle registered read data.
- After reset it zeroises data memory with a sweep FSM and raises busy, which the top level uses to hold the core in reset.
- Instruction memory is preloaded through a dedicated load port.

Parameters:
IAW, 10, log2 of instruction memory depth in 32-bit words
DAW, 10, log2 of data memory depth in 32-bit words
IBASE, 32'h80000000, word index of the first instruction word; the core fetch address is a word index
DBASE, 32'h00000000, byte address of data memory window start; aligned to 2^(DAW+2)

Ports:
clk       input   1   clock, rising edge
rst       input   1   asynchronous reset, active-high
addr      input   32  core fetch address, word index
din       output  32  instruction word to core
mem_addr  input   32  core data byte address
ddatout   input   32  core write data, already byte-merged by core
ddatin    output  32  read data to core
rw        input   1   1 = write, 0 = read
en        input   1   data access request, single-cycle qualifier
ld_en     input   1   instruction preload write strobe
ld_addr   input   IAW instruction preload word index, relative to IBASE
ld_data   input   32  instruction preload data
busy      output  1   high during zeroise sweep; core must be held in reset
err       output  1   one-cycle pulse on out-of-window data access

Behaviour:
- Reset (async, rst=1):
  - FSM enters CLEAR; clr_idx=0; busy=1; ddatin=0; err=0.
  - Instruction memory contents are not reset.
  - Reset mid-sweep restarts the sweep at index 0.
- FSM states:
  - CLEAR: each cycle writes dmem[clr_idx]=0 and increments clr_idx. When clr_idx==2^DAW-1, that word is written and the FSM moves to IDLE on the same edge.
  - Sweep takes exactly 2^DAW cycles after rst falls. busy is 1 throughout CLEAR, including the final write cycle, and 0 from the first IDLE cycle.
  - IDLE: terminal state until the next reset.
- Fetch:
  - din is combinational.
  - If IBASE <= addr < IBASE+2^IAW, din = imem[addr-IBASE]; otherwise din = 0. Opcode 0 is illegal, so the core traps.
  - Fetch is valid in all states.
- Preload:
  - ld_en=1 writes imem[ld_addr]=ld_data at the clock edge. Allowed in any state.
  - The new value is visible on din from the next cycle.
- Data window hit: mem_addr[31:DAW+2] == DBASE[31:DAW+2]. Word index = mem_addr[DAW+1:2]; mem_addr[1:0] is ignored, since lane selection and misalignment checks are the core's job.
- Read (IDLE, en=1, rw=0, hit): ddatin <= dmem[idx] at the edge, giving one-cycle latency.
- ddatin update rule:
  - ddatin is registered every cycle in IDLE from the word at the current mem_addr, whether or not en is asserted. This gives the core the word at its previous mem_addr.
  - On a miss, ddatin <= 0.
  - In CLEAR, ddatin holds 0.
- Write (IDLE, en=1, rw=1, hit): dmem[idx] <= ddatout at the edge.
- Read-during-write, same index: ddatin returns the old word (read-first). The new word is visible the following cycle.
- Miss with en=1 in IDLE:
  - err=1 for exactly one cycle; the write is suppressed; ddatin=0.
  - err is 0 whenever en=0, and always 0 in CLEAR.
- Any data request (en=1) in CLEAR is ignored: no write, no err.
- Widths and arithmetic:
  - addr-IBASE uses 32-bit unsigned arithmetic with compare-before-subtract.
  - clr_idx is DAW bits wide and does not wrap past the terminal count.

Decomposition:
- Package riscv_mem_pkg:
  - FSM state encoding (CLEAR, IDLE).
  - Default IBASE/DBASE constants.
  - ILLEGAL_INSN = 32'h00000000.
- Sub-module riscv_dmem_bank:
  - Single-port synchronous RAM, read-first.
  - One write port, muxed between the sweep and the core store.
- The responder top holds the FSM, window decode, imem array and err generation.

Test Plan (IAW=4, DAW=4, IBASE=32'h80000000, DBASE=0):
1. Pulse rst for 3 cycles, then release -> busy=1 for exactly 16 cycles then 0; after the sweep, reads of indices 0..15 return 32'h0.
2. Preload ld_addr=0 with 32'h00500093 and ld_addr=1 with 32'h00A00113; drive addr=32'h80000001 -> din=32'h00A00113 the next cycle. Drive addr=32'h80000010 -> din=0.
3. Store en=1 rw=1 mem_addr=32'h8 ddatout=32'hDEADBEEF, then read mem_addr=32'hA -> ddatin=32'hDEADBEEF one cycle after the read cycle.
4. Read-during-write: with word 2 = 32'h11111111, write 32'h22222222 to mem_addr=32'h8 while reading the same address -> ddatin=32'h11111111 that cycle, 32'h22222222 the next.
5. en=1 rw=1 mem_addr=32'h40 -> err pulses 1 for one cycle, ddatin=0, and every dmem word is unchanged.
6. Assert rst at sweep cycle 7, then release -> busy restarts and stays high a full 16 cycles. Imem preload data survives. A store attempted during CLEAR is not written and err stays 0.

Source files
------------

// File: rtl/riscv_mem_pkg.sv
// Shared types and constants for the riscv_core memory responder.
package riscv_mem_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } mem_state_t;

  localparam logic [31:0] IBASE_DEFAULT = 32'h8000_0000;
  localparam logic [31:0] DBASE_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] ILLEGAL_INSN  = 32'h0000_0000;

endpackage

// File: rtl/riscv_mem_responder_if.sv
// Fetch and data bus between riscv_core (master) and the memory responder (slave).
interface riscv_mem_responder_if;
  logic [31:0] addr;
  logic [31:0] din;
  logic [31:0] mem_addr;
  logic [31:0] ddatout;
  logic [31:0] ddatin;
  logic        rw;
  logic        en;
  logic        err;

  modport master (
    output addr, mem_addr, ddatout, rw, en,
    input  din, ddatin, err
  );

  modport slave (
    input  addr, mem_addr, ddatout, rw, en,
    output din, ddatin, err
  );
endinterface

// File: rtl/riscv_dmem_bank.sv
// Single-port read-first data RAM with a registered read port.
module riscv_dmem_bank #(
  parameter int unsigned AW = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] addr,
  input  logic          we,
  input  logic [31:0]   wdata,
  input  logic          rd_zero,
  output logic [31:0]   rdata
);

  logic [31:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  // Read register samples the pre-write word, giving read-first behaviour.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          rdata <= '0;
    else if (rd_zero) rdata <= '0;
    else              rdata <= mem[addr];
  end

endmodule

// File: rtl/riscv_mem_responder.sv
// Instruction/data memory responder: combinational fetch, registered data reads,
// post-reset zeroise sweep of data memory signalled by busy.
module riscv_mem_responder
  import riscv_mem_pkg::*;
#(
  parameter int unsigned IAW   = 10,
  parameter int unsigned DAW   = 10,
  parameter logic [31:0] IBASE = IBASE_DEFAULT,
  parameter logic [31:0] DBASE = DBASE_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  riscv_mem_responder_if.slave  bus,
  input  logic                  ld_en,
  input  logic [IAW-1:0]        ld_addr,
  input  logic [31:0]           ld_data,
  output logic                  busy
);

  localparam logic [31:0]    IDEPTH   = 32'(1) << IAW;
  localparam logic [DAW-1:0] CLR_LAST = '1;

  mem_state_t     state, state_n;
  logic [DAW-1:0] clr_idx, clr_idx_n;

  logic [31:0]    imem [2**IAW];
  logic [31:0]    ioff;

  logic           hit;
  logic [DAW-1:0] idx;
  logic           unused_lane_bits;

  logic [DAW-1:0] bank_addr;
  logic           bank_we;
  logic [31:0]    bank_wdata;
  logic           rd_zero;

  assign hit              = (bus.mem_addr[31:DAW+2] == DBASE[31:DAW+2]);
  assign idx              = bus.mem_addr[DAW+1:2];
  assign unused_lane_bits = ^bus.mem_addr[1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= CLEAR;
      clr_idx <= '0;
    end else begin
      state   <= state_n;
      clr_idx <= clr_idx_n;
    end
  end

  // The sweep owns the RAM port during CLEAR; core requests are dropped.
  always_comb begin
    state_n    = state;
    clr_idx_n  = clr_idx;
    bank_addr  = idx;
    bank_we    = 1'b0;
    bank_wdata = bus.ddatout;
    rd_zero    = 1'b1;
    case (state)
      CLEAR: begin
        bank_addr  = clr_idx;
        bank_we    = 1'b1;
        bank_wdata = '0;
        if (clr_idx == CLR_LAST) state_n = IDLE;
        else                     clr_idx_n = clr_idx + 1'b1;
      end
      IDLE: begin
        bank_we = bus.en & bus.rw & hit;
        rd_zero = ~hit;
      end
      default: state_n = CLEAR;
    endcase
  end

  assign busy    = (state == CLEAR);
  assign bus.err = (state == IDLE) & bus.en & ~hit;

  riscv_dmem_bank #(
    .AW (DAW)
  ) u_bank (
    .clk     (clk),
    .rst     (rst),
    .addr    (bank_addr),
    .we      (bank_we),
    .wdata   (bank_wdata),
    .rd_zero (rd_zero),
    .rdata   (bus.ddatin)
  );

  always_ff @(posedge clk) begin
    if (ld_en) imem[ld_addr] <= ld_data;
  end

  // Lower bound is checked before the offset is trusted, so no wrap is possible.
  always_comb begin
    ioff    = bus.addr - IBASE;
    bus.din = ILLEGAL_INSN;
    if ((bus.addr >= IBASE) && (ioff < IDEPTH)) bus.din = imem[ioff[IAW-1:0]];
  end

endmodule
